pipeline_chroma_calibrate: RTL and testbench

- Auto-calibration front end for the chroma keyer: measures the real green-screen colour so the key threshold tracks lighting instead of a hard-coded constant.
- On request, averages RGB565 foreground pixels inside a fixed 2^L x 2^L sample window over one whole frame.
- Publishes the mean key colour and a green threshold (mean green minus margin). The keyer consumes these in place of its static GREEN_PASS value.
- Sits beside the keyer on the foreground pixel stream; reads only, never modifies pixels.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/chroma_window_accum.sv | 91 +++++++++
 rtl/pipeline_chroma_calibrate.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_chroma_calibrate.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module : pipeline_pkg
// Brief  : Shared definitions for the chroma pipeline: RGB565 field positions,
//          calibration state encoding and the default green threshold that
//          the keyer and the calibrator both start from.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  // RGB565 field positions: R[15:11] G[10:5] B[4:0]
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  // Green threshold used before any calibration has completed
  localparam logic [5:0] KEY_DEFAULT_THRESHOLD = 6'd16;

  // Calibration sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ACCUM   = 2'd2,
    COMPUTE = 2'd3
  } calib_state_t;

endpackage : pipeline_pkg

`default_nettype wire

// File: rtl/chroma_window_accum.sv
// ============================================================================
// Module : chroma_window_accum
// Brief  : Sample-window hit test plus RGB sums and sample counter. 'clear'
//          zeroes the running totals; 'enable' admits the current pixel if it
//          falls in the window. Both may be high together, in which case the
//          totals restart from this pixel.
//          Optional: PIPELINE_CHROMA_CALIBRATE_MINMAX_EN adds a minimum-green
//          tracker over window samples.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module chroma_window_accum
  import pipeline_pkg::*;
#(
  parameter int WIN_X0   = 0,
  parameter int WIN_Y0   = 0,
  parameter int WIN_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    pixel_valid,
  input  logic [10:0]             pixel_x,
  input  logic [9:0]              pixel_y,
  input  logic [15:0]             pixel,
  output logic [5+2*WIN_LOG2-1:0] sum_r,
  output logic [6+2*WIN_LOG2-1:0] sum_g,
  output logic [5+2*WIN_LOG2-1:0] sum_b,
  output logic [2*WIN_LOG2:0]     count
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
  ,
  output logic [5:0]              min_g
`endif
);

  localparam int SIDE = 1 << WIN_LOG2;
  localparam int RBW  = 5 + 2 * WIN_LOG2;
  localparam int GW   = 6 + 2 * WIN_LOG2;
  localparam int CW   = 2 * WIN_LOG2 + 1;

  logic       in_x;
  logic       in_y;
  logic       take;
  logic [4:0] pix_r;
  logic [5:0] pix_g;
  logic [4:0] pix_b;

  assign pix_r = pixel[R_HI:R_LO];
  assign pix_g = pixel[G_HI:G_LO];
  assign pix_b = pixel[B_HI:B_LO];

  assign in_x = (int'(pixel_x) >= WIN_X0) && (int'(pixel_x) < WIN_X0 + SIDE);
  assign in_y = (int'(pixel_y) >= WIN_Y0) && (int'(pixel_y) < WIN_Y0 + SIDE);
  assign take = enable && pixel_valid && in_x && in_y;

  // Running sums and count; clear restarts the base, take adds the pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= '0;
      sum_g <= '0;
      sum_b <= '0;
      count <= '0;
    end else begin
      sum_r <= (clear ? RBW'(0) : sum_r) + (take ? RBW'(pix_r) : RBW'(0));
      sum_g <= (clear ? GW'(0)  : sum_g) + (take ? GW'(pix_g)  : GW'(0));
      sum_b <= (clear ? RBW'(0) : sum_b) + (take ? RBW'(pix_b) : RBW'(0));
      count <= (clear ? CW'(0)  : count) + (take ? CW'(1)      : CW'(0));
    end
  end

`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
  logic [5:0] min_base;
  assign min_base = clear ? 6'd63 : min_g;

  // Minimum green over window samples, restarting at full scale on clear
  always_ff @(posedge clk) begin
    if (rst) begin
      min_g <= 6'd63;
    end else if (take && (pix_g < min_base)) begin
      min_g <= pix_g;
    end else begin
      min_g <= min_base;
    end
  end
`endif

endmodule : chroma_window_accum

`default_nettype wire

// File: rtl/pipeline_chroma_calibrate.sv
// ============================================================================
// Module : pipeline_chroma_calibrate
// Brief  : Green-screen auto-calibration. On request, averages RGB565 pixels
//          in a 2^L x 2^L window over one full frame and publishes the mean
//          key colour plus a green threshold (mean green minus margin,
//          clamped at zero). An incomplete window raises calib_err instead.
//          Optional: PIPELINE_CHROMA_CALIBRATE_MINMAX_EN derives the threshold
//          from the minimum window green and exposes it on key_g_min.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_chroma_calibrate
  import pipeline_pkg::*;
#(
  parameter int         WIN_X0            = 0,
  parameter int         WIN_Y0            = 0,
  parameter int         WIN_LOG2          = 4,
  parameter int         MARGIN            = 8,
  parameter logic [5:0] DEFAULT_THRESHOLD = KEY_DEFAULT_THRESHOLD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_valid,
  input  logic        frame_start,
  input  logic [10:0] pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [15:0] fg_pixel_in,
  input  logic        calib_req,
  output logic        busy,
  output logic        done,
  output logic        calib_err,
  output logic        key_valid,
  output logic [4:0]  key_r,
  output logic [5:0]  key_g,
  output logic [4:0]  key_b,
  output logic [5:0]  green_threshold
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
  ,
  output logic [5:0]  key_g_min
`endif
);

  localparam int                  SH         = 2 * WIN_LOG2;
  localparam logic [2*WIN_LOG2:0] FULL_COUNT = {1'b1, {(2*WIN_LOG2){1'b0}}};

  calib_state_t state_q;
  calib_state_t state_d;
  logic         acc_clear;
  logic         acc_en;

  logic [5+SH-1:0] sum_r;
  logic [6+SH-1:0] sum_g;
  logic [5+SH-1:0] sum_b;
  logic [SH:0]     count;

  logic [4:0]        mean_r;
  logic [5:0]        mean_g;
  logic [4:0]        mean_b;
  logic [5:0]        thr_base;
  logic signed [6:0] thr_diff;
  logic [5:0]        thr_next;
  logic              window_full;
  logic              unused_lsbs;

  chroma_window_accum #(
    .WIN_X0   (WIN_X0),
    .WIN_Y0   (WIN_Y0),
    .WIN_LOG2 (WIN_LOG2)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear),
    .enable      (acc_en),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel       (fg_pixel_in),
    .sum_r       (sum_r),
    .sum_g       (sum_g),
    .sum_b       (sum_b),
    .count       (count)
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
    ,
    .min_g       (thr_base)
`endif
  );

  // Means are exact power-of-two divides: keep the top field-width bits
  assign mean_r      = sum_r[SH +: 5];
  assign mean_g      = sum_g[SH +: 6];
  assign mean_b      = sum_b[SH +: 5];
  assign unused_lsbs = ^{sum_r[SH-1:0], sum_g[SH-1:0], sum_b[SH-1:0]};

`ifndef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
  assign thr_base = mean_g;
`endif

  // Signed 7-bit subtract so an underflow shows up as a negative sign bit
  assign thr_diff    = $signed({1'b0, thr_base}) - $signed(7'(MARGIN));
  assign thr_next    = thr_diff[6] ? 6'd0 : thr_diff[5:0];
  assign window_full = (count == FULL_COUNT);

  assign busy = (state_q != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and accumulator controls; the opening frame_start pixel is
  // admitted, the closing frame_start pixel is not
  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (calib_req) state_d = ARMED;
      end
      ARMED: begin
        acc_clear = 1'b1;
        if (frame_start) begin
          acc_en  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (frame_start) begin
          state_d = COMPUTE;
        end else begin
          acc_en = 1'b1;
        end
      end
      COMPUTE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result registers and the done / error pulses, updated only in COMPUTE
  always_ff @(posedge clk) begin
    if (rst) begin
      done            <= 1'b0;
      calib_err       <= 1'b0;
      key_valid       <= 1'b0;
      key_r           <= 5'd0;
      key_g           <= 6'd0;
      key_b           <= 5'd0;
      green_threshold <= DEFAULT_THRESHOLD;
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
      key_g_min       <= 6'd0;
`endif
    end else begin
      done      <= 1'b0;
      calib_err <= 1'b0;
      if (state_q == COMPUTE) begin
        if (window_full) begin
          key_r           <= mean_r;
          key_g           <= mean_g;
          key_b           <= mean_b;
          green_threshold <= thr_next;
          key_valid       <= 1'b1;
          done            <= 1'b1;
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
          key_g_min       <= thr_base;
`endif
        end else begin
          calib_err <= 1'b1;
        end
      end
    end
  end

endmodule : pipeline_chroma_calibrate

`default_nettype wire

// File: tb/tb_pipeline_chroma_calibrate.sv
// ============================================================================
// Module : tb_pipeline_chroma_calibrate
// Brief  : Directed-plus-random bench for pipeline_chroma_calibrate. A main
//          instance uses the default window at the raster origin; a second
//          instance places its window at column 1020 so it never fills.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_chroma_calibrate;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] p;
  } px_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_valid;
  logic        frame_start;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic [15:0] fg_pixel_in;
  logic        calib_req;

  logic       busy, done, calib_err, key_valid;
  logic [4:0] key_r, key_b;
  logic [5:0] key_g, green_threshold;
  logic       off_busy, off_done, off_err, off_valid;
  logic [4:0] off_r, off_b;
  logic [5:0] off_g, off_thr;
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
  logic [5:0] key_g_min, off_g_min;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  px_t q[$];

  // Expected published results (reset values to start)
  int exp_r = 0, exp_g = 0, exp_b = 0, exp_thr = 16, exp_valid = 0, exp_min = 0;

  pipeline_chroma_calibrate dut (
    .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .fg_pixel_in(fg_pixel_in),
    .calib_req(calib_req), .busy(busy), .done(done), .calib_err(calib_err),
    .key_valid(key_valid), .key_r(key_r), .key_g(key_g), .key_b(key_b),
    .green_threshold(green_threshold)
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
    , .key_g_min(key_g_min)
`endif
  );

  pipeline_chroma_calibrate #(.WIN_X0(1020)) dut_off (
    .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .fg_pixel_in(fg_pixel_in),
    .calib_req(calib_req), .busy(off_busy), .done(off_done), .calib_err(off_err),
    .key_valid(off_valid), .key_r(off_r), .key_g(off_g), .key_b(off_b),
    .green_threshold(off_thr)
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
    , .key_g_min(off_g_min)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix_gen(input int mode, input int y);
    logic [15:0] r;
    case (mode)
      0:       r = 16'h07E0;
      1:       r = (y < 8) ? 16'h07E0 : 16'h0400;
      2:       r = 16'h0080;
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  // Raster: columns 0..31 and 1008..1023 of each row, frame_start on the first
  task automatic drive_frame(input int mode, input int rows, input bit log_it);
    for (int y = 0; y < rows; y++) begin
      for (int i = 0; i < 48; i++) begin
        int          x;
        logic [15:0] p;
        x = (i < 32) ? i : i + 976;
        p = pix_gen(mode, y);
        frame_start = (y == 0 && i == 0);
        pixel_valid = 1'b1;
        pixel_x     = 11'(x);
        pixel_y     = 10'(y);
        fg_pixel_in = p;
        if (log_it) q.push_back('{x, y, p});
        tick();
      end
    end
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_published(input string tag);
    check({tag, "_key_r"}, key_r, exp_r);
    check({tag, "_key_g"}, key_g, exp_g);
    check({tag, "_key_b"}, key_b, exp_b);
    check({tag, "_thr"}, green_threshold, exp_thr);
    check({tag, "_key_valid"}, key_valid, exp_valid);
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
    check({tag, "_key_g_min"}, key_g_min, exp_min);
`endif
  endtask

  // One full calibration: request, one accumulation frame, closing frame_start
  task automatic run_cal(input string tag, input int mode, input int rows, input bit dup);
    int sr, sg, sb, n, mn, base, base_done;
    bit ok;
    base_done = done_cnt;
    calib_req = 1'b1;
    tick();
    calib_req = 1'b0;
    check({tag, "_busy_armed"}, busy, 1);
    tick();
    if (dup) calib_req = 1'b1;
    tick();
    calib_req = 1'b0;
    tick();
    q.delete();
    drive_frame(mode, rows, 1'b1);
    // closing frame_start carries a bright in-window pixel that must be ignored
    frame_start = 1'b1;
    pixel_valid = 1'b1;
    pixel_x     = 11'd0;
    pixel_y     = 10'd0;
    fg_pixel_in = 16'hFFFF;
    tick();
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    check({tag, "_busy_n1"}, busy, 1);
    check({tag, "_done_n1"}, done, 0);
    check({tag, "_err_n1"}, calib_err, 0);
    // reference: plain averages of logged in-window pixels
    sr = 0; sg = 0; sb = 0; n = 0; mn = 63;
    foreach (q[i]) begin
      if (q[i].x < 16 && q[i].y < 16) begin
        sr += int'(q[i].p[15:11]);
        sg += int'(q[i].p[10:5]);
        sb += int'(q[i].p[4:0]);
        if (int'(q[i].p[10:5]) < mn) mn = int'(q[i].p[10:5]);
        n++;
      end
    end
    ok = (n == 256);
    if (ok) begin
      exp_r = sr / 256;
      exp_g = sg / 256;
      exp_b = sb / 256;
      exp_valid = 1;
      exp_min = mn;
`ifdef PIPELINE_CHROMA_CALIBRATE_MINMAX_EN
      base = mn;
`else
      base = exp_g;
`endif
      exp_thr = (base > 8) ? base - 8 : 0;
    end
    tick();
    check({tag, "_done_n2"}, done, ok ? 1 : 0);
    check({tag, "_err_n2"}, calib_err, ok ? 0 : 1);
    check({tag, "_busy_n2"}, busy, 0);
    check_published(tag);
    check({tag, "_off_err"}, off_err, 1);
    check({tag, "_off_done"}, off_done, 0);
    check({tag, "_off_busy"}, off_busy, 0);
    check({tag, "_off_valid"}, off_valid, 0);
    check({tag, "_off_thr"}, off_thr, 16);
    tick();
    check({tag, "_done_single"}, done, 0);
    check({tag, "_err_single"}, calib_err, 0);
    check({tag, "_done_count"}, done_cnt - base_done, ok ? 1 : 0);
  endtask

  initial begin
    int base_done;
    rst = 1'b1;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    fg_pixel_in = '0;
    calib_req = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", calib_err, 0);
    check_published("rst");
    rst = 1'b0;
    tick();

    // Idle for two frames: nothing may change
    base_done = done_cnt;
    drive_frame(0, 20, 1'b0);
    drive_frame(0, 20, 1'b0);
    check("idle_busy", busy, 0);
    check("idle_done_count", done_cnt - base_done, 0);
    check_published("idle");

    run_cal("green", 0, 20, 1'b0);
    run_cal("half", 1, 20, 1'b0);
    run_cal("dark", 2, 20, 1'b0);
    run_cal("trunc", 0, 10, 1'b0);
    for (int k = 0; k < 3; k++) run_cal($sformatf("rand%0d", k), 3, 20, 1'b0);

    // Reset mid-accumulation discards everything
    calib_req = 1'b1;
    tick();
    calib_req = 1'b0;
    drive_frame(3, 5, 1'b0);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_r = 0; exp_g = 0; exp_b = 0; exp_thr = 16; exp_valid = 0; exp_min = 0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check_published("midrst");
    tick();

    // New run with a second request while busy; only one done may follow
    base_done = done_cnt;
    run_cal("dup", 3, 20, 1'b1);
    drive_frame(0, 20, 1'b0);
    drive_frame(0, 20, 1'b0);
    check("dup_busy_after", busy, 0);
    check("dup_done_total", done_cnt - base_done, 1);
    check_published("dup_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_chroma_calibrate

`default_nettype wire
